// File: rtl/ui_pkg.sv
// Shared UI helpers: millisecond-to-cycle conversion, counter width sizing
// and the default button count used by the UI controller.
package ui_pkg;

    localparam int UI_N_BTN = 4;

    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

    // One spare bit over clog2 so a counter holding cycles-1 can never wrap.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/ui_btn_channel.sv
// One button channel: optional inversion, 2-FF synchroniser, debounce counter,
// press/release pulses; auto-repeat is built only when BTN_REPEAT_EN is defined.
module ui_btn_channel
    import ui_pkg::*;
#(
    parameter int DB         = 4,
`ifdef BTN_REPEAT_EN
    parameter int RD         = 20,
    parameter int RR         = 5,
`endif
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic CLK12,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int DW = cnt_width(DB);
    localparam logic [DW-1:0] DB_LAST = DW'(DB - 1);

    logic          sync1_q, sync1_d;
    logic          s_q, s_d;
    logic          level_q, level_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          rpt_pulse;

    always_comb begin
        sync1_d = ACTIVE_LOW ? ~btn_raw : btn_raw;
        s_d     = sync1_q;
        level_d = level_q;
        dcnt_d  = '0;
        if (s_q != level_q) begin
            if (dcnt_q == DB_LAST) begin
                level_d = s_q;
            end else begin
                dcnt_d = dcnt_q + DW'(1);
            end
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int RW = cnt_width(RD);
    localparam logic [RW-1:0] RD_LAST = RW'(RD - 1);
    localparam logic [RW-1:0] RR_LAST = RW'(RR - 1);

    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          first_q, first_d;

    // Counter runs only while the level is held across a whole cycle, so it
    // is cleared on the press cycle and can never fire on the release cycle.
    always_comb begin
        rcnt_d    = '0;
        first_d   = 1'b1;
        rpt_pulse = 1'b0;
        if (level_d && level_q) begin
            first_d = first_q;
            if (rcnt_q == (first_q ? RD_LAST : RR_LAST)) begin
                rpt_pulse = 1'b1;
                first_d   = 1'b0;
            end else begin
                rcnt_d = rcnt_q + RW'(1);
            end
        end
    end

    always_ff @(posedge CLK12) begin
        if (!rst_n) begin
            rcnt_q  <= '0;
            first_q <= 1'b1;
        end else begin
            rcnt_q  <= rcnt_d;
            first_q <= first_d;
        end
    end
`else
    assign rpt_pulse = 1'b0;
`endif

    always_comb begin
        press_d   = (level_d & ~level_q) | rpt_pulse;
        release_d = ~level_d & level_q;
    end

    always_ff @(posedge CLK12) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            s_q       <= 1'b0;
            level_q   <= 1'b0;
            dcnt_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            s_q       <= s_d;
            level_q   <= level_d;
            dcnt_q    <= dcnt_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: rtl/ui_button_debounce.sv
// Front-panel button conditioner: N_BTN independent debounce channels.
// Define BTN_REPEAT_EN to add auto-repeat press pulses while a button is held.
module ui_button_debounce
    import ui_pkg::*;
#(
    parameter int N_BTN           = UI_N_BTN,
    parameter int CLK_HZ          = 12000000,
    parameter int DEBOUNCE_MS     = 10,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 100,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic             CLK12,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    localparam int DB = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);

    if (DB < 1) begin : g_bad_db
        $error("ui_button_debounce: debounce time must be at least one cycle");
    end

`ifdef BTN_REPEAT_EN
    localparam int RD = ms_to_cycles(CLK_HZ, REPEAT_DELAY_MS);
    localparam int RR = ms_to_cycles(CLK_HZ, REPEAT_RATE_MS);

    if (RR < 1 || RD < RR) begin : g_bad_rpt
        $error("ui_button_debounce: need repeat rate >= 1 cycle and delay >= rate");
    end
`else
    localparam int unused_repeat_cfg = REPEAT_DELAY_MS + REPEAT_RATE_MS;
`endif

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        ui_btn_channel #(
            .DB         (DB),
`ifdef BTN_REPEAT_EN
            .RD         (RD),
            .RR         (RR),
`endif
            .ACTIVE_LOW (BTN_ACTIVE_LOW)
        ) u_ch (
            .CLK12       (CLK12),
            .rst_n       (rst_n),
            .btn_raw     (btn_raw[i]),
            .btn_level   (btn_level[i]),
            .btn_press   (btn_press[i]),
            .btn_release (btn_release[i])
        );
    end

endmodule

// File: tb/tb_ui_button_debounce.sv
// Bench for ui_button_debounce at 1 kHz (DB=4, RD=20, RR=5, active-low pins).
module tb_ui_button_debounce;

    localparam int N  = 4;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RR = 5;

    logic         CLK12 = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] btn_raw = '1;
    logic [N-1:0] btn_level, btn_press, btn_release;

    int vectors = 0;
    int errors  = 0;

    always #5 CLK12 = ~CLK12;

    ui_button_debounce #(
        .N_BTN(N), .CLK_HZ(1000), .DEBOUNCE_MS(4),
        .REPEAT_DELAY_MS(20), .REPEAT_RATE_MS(5), .BTN_ACTIVE_LOW(1'b1)
    ) dut (
        .CLK12(CLK12), .rst_n(rst_n), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
    );

    // Reference: a level flips once the pressed state seen through the two
    // synchroniser stages has disagreed with it for DB consecutive edges.
    // Repeats are derived from the elapsed time since the press pulse.
    logic [N-1:0] samp [0:DB+1];
    logic [N-1:0] m_level, m_press, m_release;
    int           t_now = 0;
    int           since [N];

    always @(posedge CLK12) begin : ref_model
        logic stable;
        int   d;
        t_now++;
        if (!rst_n) begin
            for (int i = 0; i <= DB + 1; i++) samp[i] = '0;
            m_level = '0; m_press = '0; m_release = '0;
        end else begin
            for (int i = DB + 1; i > 0; i--) samp[i] = samp[i-1];
            samp[0] = ~btn_raw;
            m_press = '0; m_release = '0;
            for (int c = 0; c < N; c++) begin
                stable = 1'b1;
                for (int i = 2; i <= DB + 1; i++)
                    if (samp[i][c] == m_level[c]) stable = 1'b0;
                if (stable) begin
                    m_level[c] = ~m_level[c];
                    if (m_level[c]) begin
                        m_press[c] = 1'b1;
                        since[c]   = t_now;
                    end else begin
                        m_release[c] = 1'b1;
                    end
                end else if (m_level[c]) begin
                    d = t_now - since[c];
`ifdef BTN_REPEAT_EN
                    if (d == RD || (d > RD && (d - RD) % RR == 0)) m_press[c] = 1'b1;
`else
                    if (d < 0) m_press[c] = 1'b1;
`endif
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK12);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; btn_raw = '1;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if ({btn_level, btn_press, btn_release} !== 12'h000) begin
                errors++;
                $display("FAIL reset_outputs: got %h want 000", {btn_level, btn_press, btn_release});
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            vectors++;
            if ({btn_level, btn_press, btn_release} !== 12'h000) begin
                errors++;
                $display("FAIL idle_after_reset: got %h want 000", {btn_level, btn_press, btn_release});
            end
        end
    endtask

    task automatic settle(input int n);
        btn_raw = '1;
        for (int k = 0; k < n; k++) begin
            tick();
            vectors++;
            if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_release}) begin
                errors++;
                $display("FAIL settle_model: got %h want %h",
                         {btn_level, btn_press, btn_release}, {m_level, m_press, m_release});
            end
        end
    endtask

    task automatic test_clean_press();
        btn_raw[0] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            vectors++;
            if (btn_level !== ((k >= 6) ? 4'b0001 : 4'b0000) ||
                btn_press !== ((k == 6) ? 4'b0001 : 4'b0000) || btn_release !== 4'b0000) begin
                errors++;
                $display("FAIL clean_press k=%0d: got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=0000",
                         k, btn_level, btn_press, btn_release,
                         (k >= 6) ? 4'b0001 : 4'b0000, (k == 6) ? 4'b0001 : 4'b0000);
            end
        end
        settle(10);
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 20; i++) begin
            btn_raw[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick();
            vectors++;
            if (btn_press !== 4'b0000 || btn_release !== 4'b0000 || btn_level !== 4'b0000) begin
                errors++;
                $display("FAIL bounce_quiet i=%0d: got lvl=%b prs=%b rel=%b want all 0000",
                         i, btn_level, btn_press, btn_release);
            end
        end
        btn_raw[1] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            vectors++;
            if (btn_level[1] !== (k >= 6) || btn_press[1] !== (k == 6)) begin
                errors++;
                $display("FAIL bounce_settle k=%0d: got lvl=%b prs=%b want lvl=%b prs=%b",
                         k, btn_level[1], btn_press[1], (k >= 6), (k == 6));
            end
        end
        settle(10);
    endtask

    task automatic test_glitch();
        int rel_cnt;
        btn_raw[2] = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        btn_raw[2] = 1'b1;
        rel_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 3) btn_raw[2] = 1'b0;
            if (btn_release[2]) rel_cnt++;
            vectors++;
            if (btn_level[2] !== 1'b1) begin
                errors++;
                $display("FAIL glitch3_level k=%0d: got %b want 1", k, btn_level[2]);
            end
        end
        vectors++;
        if (rel_cnt !== 0) begin
            errors++;
            $display("FAIL glitch3_release_count: got %0d want 0", rel_cnt);
        end
        btn_raw[2] = 1'b1;
        rel_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k == 4) btn_raw[2] = 1'b0;
            if (btn_release[2]) rel_cnt++;
            vectors++;
            if (btn_release[2] !== (k == 6) || btn_level[2] !== (k < 6 || k >= 10)) begin
                errors++;
                $display("FAIL glitch4 k=%0d: got rel=%b lvl=%b want rel=%b lvl=%b",
                         k, btn_release[2], btn_level[2], (k == 6), (k < 6 || k >= 10));
            end
        end
        vectors++;
        if (rel_cnt !== 1) begin
            errors++;
            $display("FAIL glitch4_release_count: got %0d want 1", rel_cnt);
        end
        settle(10);
    endtask

    task automatic test_auto_repeat();
        bit found, exp_p;
        found = 1'b0;
        btn_raw[3] = 1'b0;
        for (int k = 1; k <= 12 && !found; k++) begin
            tick();
            if (btn_press[3]) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            errors++;
            $display("FAIL repeat_first_press: got no press within 12 cycles want one");
        end
        for (int off = 1; off <= 62; off++) begin
            if (off == 46) btn_raw[3] = 1'b1;
            tick();
`ifdef BTN_REPEAT_EN
            exp_p = (off <= 50) && (off == RD || (off > RD && (off - RD) % RR == 0));
`else
            exp_p = 1'b0;
`endif
            vectors++;
            if (btn_press[3] !== exp_p || btn_release[3] !== (off == 51)) begin
                errors++;
                $display("FAIL repeat off=%0d: got prs=%b rel=%b want prs=%b rel=%b",
                         off, btn_press[3], btn_release[3], exp_p, (off == 51));
            end
        end
        settle(4);
    endtask

    task automatic test_simultaneous();
        btn_raw = 4'b0000;
        for (int k = 1; k <= 6; k++) begin
            tick();
            vectors++;
            if (btn_press !== ((k == 6) ? 4'b1111 : 4'b0000)) begin
                errors++;
                $display("FAIL simul_press k=%0d: got %b want %b", k, btn_press,
                         (k == 6) ? 4'b1111 : 4'b0000);
            end
        end
        btn_raw = 4'b0011;
        for (int k = 1; k <= 8; k++) begin
            tick();
            vectors++;
            if (btn_release !== ((k == 6) ? 4'b0011 : 4'b0000) ||
                btn_level !== ((k >= 6) ? 4'b1100 : 4'b1111)) begin
                errors++;
                $display("FAIL simul_release k=%0d: got rel=%b lvl=%b want rel=%b lvl=%b",
                         k, btn_release, btn_level, (k == 6) ? 4'b0011 : 4'b0000,
                         (k >= 6) ? 4'b1100 : 4'b1111);
            end
        end
        settle(10);
    endtask

    task automatic test_reset_mid_hold();
        btn_raw[0] = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            vectors++;
            if ({btn_level, btn_press, btn_release} !== 12'h000) begin
                errors++;
                $display("FAIL midreset_outputs: got %h want 000", {btn_level, btn_press, btn_release});
            end
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            vectors++;
            if (btn_press !== ((k == 6) ? 4'b0001 : 4'b0000) ||
                btn_level !== ((k >= 6) ? 4'b0001 : 4'b0000)) begin
                errors++;
                $display("FAIL midreset_press k=%0d: got prs=%b lvl=%b want prs=%b lvl=%b",
                         k, btn_press, btn_level, (k == 6) ? 4'b0001 : 4'b0000,
                         (k >= 6) ? 4'b0001 : 4'b0000);
            end
        end
        settle(10);
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 5) == 0) btn_raw[c] = ~btn_raw[c];
            tick();
            vectors++;
            if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_release}) begin
                errors++;
                $display("FAIL random_model k=%0d: got lvl=%b prs=%b rel=%b want lvl=%b prs=%b rel=%b",
                         k, btn_level, btn_press, btn_release, m_level, m_press, m_release);
            end
        end
        settle(40);
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_auto_repeat();
        test_simultaneous();
        test_reset_mid_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/ui_button_debounce.md
# ui_button_debounce

Conditions the raw front-panel push buttons ahead of the UI controller. It synchronises each button to CLK12 and debounces it with a cycle-exact stability counter. It then emits a clean level plus single-cycle press/release pulses, which are what the UI menu logic consumes. An optional auto-repeat generates periodic press pulses while a button is held, for stepping gain/TC/ref settings.

## Interface
- N_BTN, 4, number of button channels
- CLK_HZ, 12000000, CLK12 frequency in Hz
- DEBOUNCE_MS, 10, required stable time before a level change is accepted
- REPEAT_DELAY_MS, 500, hold time from the press pulse to the first repeat pulse
- REPEAT_RATE_MS, 100, interval between subsequent repeat pulses
- BTN_ACTIVE_LOW, 1, 1 means the raw pin reads 0 when pressed; inversion is done internally
- CLK12  in  1  system clock, all logic on the rising edge
- rst_n  in  1  reset, synchronous and active-low
- btn_raw  in  N_BTN  asynchronous raw button pins
- btn_level  out  N_BTN  debounced state, 1 = pressed
- btn_press  out  N_BTN  one-cycle pulse on an accepted press, and on each repeat
- btn_release  out  N_BTN  one-cycle pulse on an accepted release

## Operation
- Derived cycle counts:
  - DB = CLK_HZ/1000*DEBOUNCE_MS
  - RD = CLK_HZ/1000*REPEAT_DELAY_MS
  - RR = CLK_HZ/1000*REPEAT_RATE_MS
  - Elaboration error unless DB≥1, RR≥1 and RD≥RR.
- Per channel, in this order:
  - Optional inversion, then a 2-FF synchroniser giving s.
  - Debounce counter dcnt, width clog2(DB)+1.
- Debounce rule, per edge:
  - If s == level: dcnt ← 0.
  - Else if dcnt == DB-1: level ← s and dcnt ← 0.
  - Else: dcnt ← dcnt+1.
  - A single-cycle glitch back to the current level restarts the count.
- Pulses:
  - btn_press is 1 in the cycle where level first reads 1.
  - btn_release is 1 in the cycle where level first reads 0.
  - Both are registered outputs and are never asserted together.
- Channels are fully independent. Simultaneous presses on several buttons produce simultaneous pulses.
- Reset values:
  - Synchroniser flops hold the "released" value after inversion.
  - All counters are 0.
  - btn_level, btn_press and btn_release are all 0.
- Reset mid-operation discards all state. A button still held after rst_n rises is treated as a new press: btn_press fires DB+2 cycles later.

## Timing
- If raw goes and stays pressed before edge e0, s changes after e1 and btn_level rises after edge e(DB+1). Latency is DB+2 cycles, fixed with no jitter.
- Release latency is identical, DB+2 cycles.
- Auto-repeat, when compiled in:
  - Repeat counter rcnt is cleared while level is 0 and on the press cycle.
  - The first repeat pulse comes RD cycles after the press pulse.
  - Subsequent repeat pulses come every RR cycles while level stays 1.
  - rcnt counts to RD-1 in the first interval and RR-1 in later ones, via a first/subsequent flag.
- Release stops repeats immediately. No repeat pulse is issued in the release cycle or after it.
- Counter widths are sized so that no wrap-around is possible.

## Configuration
- BTN_REPEAT_EN
  - Defined: repeat counters and flag are built per channel; btn_press carries the press pulse plus the repeat pulses.
  - Undefined: no repeat logic is synthesised, and REPEAT_* parameters are ignored; btn_press fires exactly once per accepted press.

## Structure
- Package ui_pkg:
  - Function ms_to_cycles(clk_hz, ms).
  - Width helper based on clog2.
  - Shared N_BTN default, reused by the UI controller.
- Sub-module ui_btn_channel:
  - One synchroniser, one debounce counter, optional repeat logic, pulse generation.
  - The top instantiates it N_BTN times with a generate loop; the top holds no other logic.

## Test plan
Bench parameters: CLK_HZ=1000, DEBOUNCE_MS=4, REPEAT_DELAY_MS=20, REPEAT_RATE_MS=5, active-low, giving DB=4, RD=20, RR=5.
- **Clean press:** hold btn_raw[0]=0 -> btn_level[0] rises exactly 6 cycles later, btn_press[0] is high for that one cycle, other channels stay 0.
- **Bounce:** toggle raw[1] pressed/released on alternate cycles for 20 cycles, then hold pressed -> no pulse during bouncing; btn_level[1] rises 6 cycles after the last transition.
- **Glitch:** with raw[2] held pressed and level high, release it for 3 cycles -> no btn_release, level stays 1. Release for 4 cycles -> btn_release once, at cycle 6 after the release began.
- **Auto-repeat (BTN_REPEAT_EN):** hold raw[3] for 50 cycles past the press pulse -> press pulses at offsets 0, 20, 25, 30, 35, 40, 45, 50; release -> no further pulses. Without the macro, only offset 0.
- **Simultaneous:** press all 4 buttons in the same cycle -> btn_press=4'b1111 in a single cycle; release two of them -> btn_release=4'b0011 with the correct latency.
- **Reset mid-hold:** assert rst_n=0 for 2 cycles while a button is held with level high -> all outputs 0 while rst_n is low; btn_press fires 6 cycles after rst_n returns high.
